// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg
// Shared types for the counter bank.
//   mode_e : counter limit behaviour.
//            MODE_WRAP rolls over modulo 2^WIDTH.
//            MODE_SAT clamps at 0 / max.
package counter_bank_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/counter_cell.sv
// counter_cell
// One channel of the counter bank: the count register, the next-state priority
// logic (clr > load > step > hold), the one-cycle boundary event flop and the
// sticky overflow flop.
// Ports:
//   clk     in  1      rising-edge clock
//   rst_n   in  1      asynchronous active-low reset
//   clr     in  1      synchronous clear of count and ovf
//   ld      in  1      load strobe already decoded for this channel
//   ld_val  in  WIDTH  value written on load
//   en      in  1      count enable
//   up      in  1      direction: 1 = increment, 0 = decrement
//   count   out WIDTH  current count (register output)
//   evt     out 1      one-cycle pulse after a step attempted at a limit
//   ovf     out 1      sticky copy of evt, cleared only by clr
module counter_cell
  import counter_bank_pkg::*;
#(
  parameter int    WIDTH = 8,
  parameter mode_e MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             evt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_next;
  logic             evt_next;
  logic             ovf_next;

  // Next-state priority logic for count, evt and ovf.
  always_comb begin
    count_next = count;
    evt_next   = 1'b0;
    ovf_next   = ovf;
    if (clr) begin
      // clr wins even over a step at a limit, so no event is raised here.
      count_next = ZERO;
      ovf_next   = 1'b0;
    end else if (ld) begin
      count_next = ld_val;
    end else if (en) begin
      if (up) begin
        if (count == MAX) begin
          count_next = (MODE == MODE_SAT) ? MAX : ZERO;
          evt_next   = 1'b1;
          ovf_next   = 1'b1;
        end else begin
          count_next = count + ONE;
        end
      end else begin
        if (count == ZERO) begin
          count_next = (MODE == MODE_SAT) ? ZERO : MAX;
          evt_next   = 1'b1;
          ovf_next   = 1'b1;
        end else begin
          count_next = count - ONE;
        end
      end
    end else begin
      count_next = count;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= ZERO;
      evt   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_next;
      evt   <= evt_next;
      ovf   <= ovf_next;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// counter_bank
// Bank of NUM_CH independent WIDTH-bit up/down counters with a shared load
// port and a registered read-back mux.
// Ports:
//   clk       in  1             rising-edge clock
//   rst_n     in  1             asynchronous active-low reset
//   en        in  NUM_CH        per-channel count enable
//   up        in  NUM_CH        per-channel direction (1 = up)
//   clr       in  NUM_CH        per-channel synchronous clear
//   load      in  1             load strobe
//   load_ch   in  CH_W          channel targeted by load (>= NUM_CH ignored)
//   load_val  in  WIDTH         value written on load
//   rd_ch     in  CH_W          read-back channel select
//   rd_val    out WIDTH         registered count of rd_ch (0 if out of range)
//   evt       out NUM_CH        one-cycle boundary-event pulse per channel
//   ovf       out NUM_CH        sticky event flag per channel
//   count     out NUM_CH*WIDTH  all counts, channel i at [i*WIDTH +: WIDTH]
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int    WIDTH  = 8,
  parameter int    NUM_CH = 4,
  parameter mode_e MODE   = MODE_WRAP,
  localparam int   CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       up,
  input  logic [NUM_CH-1:0]       clr,
  input  logic                    load,
  input  logic [CH_W-1:0]         load_ch,
  input  logic [WIDTH-1:0]        load_val,
  input  logic [CH_W-1:0]         rd_ch,
  output logic [WIDTH-1:0]        rd_val,
  output logic [NUM_CH-1:0]       evt,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH*WIDTH-1:0] count
);

  logic [WIDTH-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] ld;
  logic [WIDTH-1:0]  rd_sel;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // An out-of-range load_ch matches no channel, so such loads are dropped.
    assign ld[g] = load & (load_ch == CH_W'(g));

    counter_cell #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr[g]),
      .ld     (ld[g]),
      .ld_val (load_val),
      .en     (en[g]),
      .up     (up[g]),
      .count  (cnt[g]),
      .evt    (evt[g]),
      .ovf    (ovf[g])
    );

    assign count[g*WIDTH +: WIDTH] = cnt[g];
  end

  // Read-back select; compares against each channel index so an out-of-range
  // rd_ch never indexes the array and simply yields zero.
  always_comb begin
    rd_sel = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      rd_sel = (rd_ch == CH_W'(i)) ? cnt[i] : rd_sel;
    end
  end

  // Registered read-back: samples the count held before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_val <= {WIDTH{1'b0}};
    end else begin
      rd_val <= rd_sel;
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank
// Three builds with WIDTH=4: A = WRAP/4 channels, B = SAT/4 channels,
// C = WRAP/3 channels. Stimulus pushes hand-computed expectations into a
// scoreboard queue; a monitor drains and compares them on each falling clock
// edge, or immediately when the stimulus signals an asynchronous check.
module tb_counter_bank;
  import counter_bank_pkg::*;

  localparam int W = 4;

  // kinds of observed values
  localparam int K_CNT = 0;
  localparam int K_RD  = 1;
  localparam int K_EVT = 2;
  localparam int K_OVF = 3;

  typedef struct {
    string name;
    int    dut;
    int    kind;
    int    ch;
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  event chk_ev;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // DUT A: WRAP, 4 channels
  logic [3:0] en_a = '0, up_a = '0, clr_a = '0;
  logic load_a = 1'b0;
  logic [1:0] load_ch_a = '0, rd_ch_a = '0;
  logic [W-1:0] load_val_a = '0, rd_val_a;
  logic [3:0] evt_a, ovf_a;
  logic [4*W-1:0] count_a;

  // DUT B: SAT, 4 channels
  logic [3:0] en_b = '0, up_b = '0, clr_b = '0;
  logic load_b = 1'b0;
  logic [1:0] load_ch_b = '0, rd_ch_b = '0;
  logic [W-1:0] load_val_b = '0, rd_val_b;
  logic [3:0] evt_b, ovf_b;
  logic [4*W-1:0] count_b;

  // DUT C: WRAP, 3 channels
  logic [2:0] en_c = '0, up_c = '0, clr_c = '0;
  logic load_c = 1'b0;
  logic [1:0] load_ch_c = '0, rd_ch_c = '0;
  logic [W-1:0] load_val_c = '0, rd_val_c;
  logic [2:0] evt_c, ovf_c;
  logic [3*W-1:0] count_c;

  counter_bank #(.WIDTH(W), .NUM_CH(4), .MODE(MODE_WRAP)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .up(up_a), .clr(clr_a),
    .load(load_a), .load_ch(load_ch_a), .load_val(load_val_a),
    .rd_ch(rd_ch_a), .rd_val(rd_val_a), .evt(evt_a), .ovf(ovf_a),
    .count(count_a));

  counter_bank #(.WIDTH(W), .NUM_CH(4), .MODE(MODE_SAT)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .up(up_b), .clr(clr_b),
    .load(load_b), .load_ch(load_ch_b), .load_val(load_val_b),
    .rd_ch(rd_ch_b), .rd_val(rd_val_b), .evt(evt_b), .ovf(ovf_b),
    .count(count_b));

  counter_bank #(.WIDTH(W), .NUM_CH(3), .MODE(MODE_WRAP)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .up(up_c), .clr(clr_c),
    .load(load_c), .load_ch(load_ch_c), .load_val(load_val_c),
    .rd_ch(rd_ch_c), .rd_val(rd_val_c), .evt(evt_c), .ovf(ovf_c),
    .count(count_c));

  always #5 clk = ~clk;

  function automatic int get_act(int dut, int kind, int ch);
    case (dut)
      0: case (kind)
           K_CNT:   return int'(count_a[ch*W +: W]);
           K_RD:    return int'(rd_val_a);
           K_EVT:   return int'(evt_a[ch]);
           default: return int'(ovf_a[ch]);
         endcase
      1: case (kind)
           K_CNT:   return int'(count_b[ch*W +: W]);
           K_RD:    return int'(rd_val_b);
           K_EVT:   return int'(evt_b[ch]);
           default: return int'(ovf_b[ch]);
         endcase
      default: case (kind)
           K_CNT:   return int'(count_c[ch*W +: W]);
           K_RD:    return int'(rd_val_c);
           K_EVT:   return int'(evt_c[ch]);
           default: return int'(ovf_c[ch]);
         endcase
    endcase
  endfunction

  task automatic push(string name, int dut, int kind, int ch, int exp);
    exp_t e;
    e.name = name; e.dut = dut; e.kind = kind; e.ch = ch; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // count, evt and ovf of one channel in one go
  task automatic push_ch(string name, int dut, int ch, int c, int ev, int ov);
    push({name, "_cnt"}, dut, K_CNT, ch, c);
    push({name, "_evt"}, dut, K_EVT, ch, ev);
    push({name, "_ovf"}, dut, K_OVF, ch, ov);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(negedge clk or chk_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = get_act(e.dut, e.kind, e.ch);
        checks++;
        if (act != e.exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    int waited;
    // power-on reset
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_ch("por_a", 0, i, 0, 0, 0);
      push_ch("por_b", 1, i, 0, 0, 0);
    end
    push("por_rd_a", 0, K_RD, 0, 0);

    // WRAP up: load ch1=14 then count up three times
    load_a = 1'b1; load_ch_a = 2'd1; load_val_a = 4'd14;
    tick();
    push_ch("wup_load", 0, 1, 14, 0, 0);
    load_a = 1'b0; en_a[1] = 1'b1; up_a[1] = 1'b1;
    tick();
    push_ch("wup_15", 0, 1, 15, 0, 0);
    tick();
    push_ch("wup_wrap", 0, 1, 0, 1, 1);
    tick();
    push_ch("wup_1", 0, 1, 1, 0, 1);
    en_a[1] = 1'b0;

    // WRAP down: ch2 at 0, one decrement
    en_a[2] = 1'b1; up_a[2] = 1'b0;
    tick();
    push_ch("wdn_wrap", 0, 2, 15, 1, 1);
    en_a[2] = 1'b0;
    tick();
    push_ch("wdn_hold", 0, 2, 15, 0, 1);

    // Priority: make ovf[3] set, then clr+load+en at the limit on one edge
    en_a[3] = 1'b1; up_a[3] = 1'b0;
    tick();
    push_ch("pri_setup", 0, 3, 15, 1, 1);
    up_a[3] = 1'b1; clr_a[3] = 1'b1;
    load_a = 1'b1; load_ch_a = 2'd3; load_val_a = 4'd9;
    tick();
    push_ch("pri_clr", 0, 3, 0, 0, 0);
    clr_a[3] = 1'b0;
    tick();
    push_ch("pri_load", 0, 3, 9, 0, 0);
    load_a = 1'b0; en_a[3] = 1'b0;

    // Read-back latency: ch2=5, select it and increment on the same edge
    load_a = 1'b1; load_ch_a = 2'd2; load_val_a = 4'd5;
    tick();
    push("rb_load", 0, K_CNT, 2, 5);
    load_a = 1'b0; rd_ch_a = 2'd2; en_a[2] = 1'b1; up_a[2] = 1'b1;
    tick();
    push("rb_edge_n", 0, K_RD, 0, 5);
    push("rb_cnt_n", 0, K_CNT, 2, 6);
    en_a[2] = 1'b0;
    tick();
    push("rb_edge_n1", 0, K_RD, 0, 6);

    // Asynchronous reset mid-count with ch0=7
    load_a = 1'b1; load_ch_a = 2'd0; load_val_a = 4'd7;
    tick();
    push("rst_pre_cnt", 0, K_CNT, 0, 7);
    push("rst_pre_ovf1", 0, K_OVF, 1, 1);
    load_a = 1'b0; en_a[0] = 1'b1; up_a[0] = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      push_ch("rst_async", 0, i, 0, 0, 0);
    end
    push("rst_async_rd", 0, K_RD, 0, 0);
    -> chk_ev;
    tick();
    push("rst_hold_cnt", 0, K_CNT, 0, 0);
    rst_n = 1'b1;
    tick();
    push("rst_resume", 0, K_CNT, 0, 1);
    en_a[0] = 1'b0;

    // SAT: ch0=15 with two up steps, ch1=0 with one down step
    load_b = 1'b1; load_ch_b = 2'd0; load_val_b = 4'd15;
    tick();
    push_ch("sat_load", 1, 0, 15, 0, 0);
    load_b = 1'b0; en_b[0] = 1'b1; up_b[0] = 1'b1;
    tick();
    push_ch("sat_up1", 1, 0, 15, 1, 1);
    tick();
    push_ch("sat_up2", 1, 0, 15, 1, 1);
    en_b[0] = 1'b0; en_b[1] = 1'b1; up_b[1] = 1'b0;
    tick();
    push_ch("sat_up_done", 1, 0, 15, 0, 1);
    push_ch("sat_dn", 1, 1, 0, 1, 1);
    en_b[1] = 1'b0;

    // NUM_CH=3: out-of-range read-back and load
    load_c = 1'b1; load_ch_c = 2'd0; load_val_c = 4'd5;
    tick();
    load_ch_c = 2'd1; load_val_c = 4'd6;
    tick();
    load_ch_c = 2'd2; load_val_c = 4'd7;
    tick();
    push("oor_rd_pre", 2, K_RD, 0, 5);
    rd_ch_c = 2'd3; load_ch_c = 2'd3; load_val_c = 4'd12;
    tick();
    push("oor_rd", 2, K_RD, 0, 0);
    push("oor_ld0", 2, K_CNT, 0, 5);
    push("oor_ld1", 2, K_CNT, 1, 6);
    push("oor_ld2", 2, K_CNT, 2, 7);
    load_c = 1'b0;

    // drain the scoreboard within a bounded number of cycles
    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
